// File: rtl/dispatch_controller_pkg.sv
// Shared sizing defaults and types for the dispatch controller slice.
package dispatch_controller_pkg;

    localparam int DEF_ROB_SIZE = 16;
    localparam int DEF_RS_SIZE  = 16;
    localparam int DEF_LSB_SIZE = 16;

    typedef enum logic {
        TgtRs  = 1'b0,
        TgtLsb = 1'b1
    } target_e;

endpackage

// File: rtl/dispatch_controller_credit_counter.sv
// Free-slot credit counter: decrements on take, increments on release, saturates at SIZE.
module dispatch_controller_credit_counter
    import dispatch_controller_pkg::*;
#(
    parameter int SIZE = DEF_RS_SIZE,
    localparam int CW  = $clog2(SIZE + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          take,
    input  logic          free,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] count,
    output logic          nonzero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= CW'(SIZE);
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            if (take && !free) begin
                count <= count - 1'b1;
            end else if (free && !take && count != CW'(SIZE)) begin
                count <= count + 1'b1;
            end
        end
    end

    assign nonzero = (count != '0);

endmodule

// File: rtl/dispatch_controller.sv
// Buffers decoded instructions and dispatches one per cycle once ROB and the target unit have space.
module dispatch_controller
    import dispatch_controller_pkg::*;
#(
    parameter int PAYLOAD_W   = 80,
    parameter int QUEUE_DEPTH = 2,
    parameter int ROB_SIZE    = DEF_ROB_SIZE,
    parameter int RS_SIZE     = DEF_RS_SIZE,
    parameter int LSB_SIZE    = DEF_LSB_SIZE,
    localparam int TAG_W      = $clog2(ROB_SIZE),
    localparam int LSB_CW     = $clog2(LSB_SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 dec_valid_in,
    input  logic                 dec_to_lsb_in,
    input  logic [PAYLOAD_W-1:0] dec_payload_in,
    output logic                 dec_ready_out,
    output logic                 issue_valid_out,
    output logic                 issue_to_lsb_out,
    output logic [PAYLOAD_W-1:0] issue_payload_out,
    output logic [TAG_W-1:0]     issue_tag_out,
    input  logic                 rob_commit_in,
    input  logic                 rs_release_in,
    input  logic                 lsb_release_in,
    input  logic                 rollback_in,
    input  logic [LSB_CW-1:0]    lsb_free_after_rollback_in
);

    localparam int PTR_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W  = $clog2(QUEUE_DEPTH + 1);
    localparam int ROB_CW = $clog2(ROB_SIZE + 1);
    localparam int RS_CW  = $clog2(RS_SIZE + 1);

    target_e              fifo_tgt  [QUEUE_DEPTH];
    logic [PAYLOAD_W-1:0] fifo_data [QUEUE_DEPTH];
    logic [PTR_W-1:0]     rd_ptr, wr_ptr;
    logic [CNT_W-1:0]     count;
    logic [TAG_W-1:0]     tag_ptr;

    logic                 rob_nz, rs_nz, lsb_nz;
    logic [ROB_CW-1:0]    rob_cr;
    logic [RS_CW-1:0]     rs_cr;
    logic [LSB_CW-1:0]    lsb_cr;
    logic                 head_lsb, target_ok, enq, fire;

    assign head_lsb  = (fifo_tgt[rd_ptr] == TgtLsb);
    assign target_ok = head_lsb ? lsb_nz : rs_nz;

    // Ready looks only at registered occupancy, so the decoder never sees a comb path via dispatch.
    assign dec_ready_out   = !rst && rdy && !rollback_in && (count < CNT_W'(QUEUE_DEPTH));
    assign fire            = !rst && rdy && !rollback_in && (count != '0) && rob_nz && target_ok;
    assign enq             = dec_valid_in && dec_ready_out;

    assign issue_valid_out   = fire;
    assign issue_to_lsb_out  = head_lsb;
    assign issue_payload_out = fifo_data[rd_ptr];
    assign issue_tag_out     = tag_ptr;

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_tgt[wr_ptr]  <= dec_to_lsb_in ? TgtLsb : TgtRs;
            fifo_data[wr_ptr] <= dec_payload_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            tag_ptr <= '0;
        end else if (rollback_in) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            tag_ptr <= '0;
        end else if (rdy) begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fire) begin
                rd_ptr  <= rd_ptr + 1'b1;
                tag_ptr <= (tag_ptr == TAG_W'(ROB_SIZE - 1)) ? '0 : tag_ptr + 1'b1;
            end
            case ({enq, fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    dispatch_controller_credit_counter #(.SIZE(ROB_SIZE)) u_rob_credit (
        .clk      (clk),
        .rst      (rst),
        .en       (rdy),
        .take     (fire),
        .free     (rob_commit_in),
        .load     (rollback_in),
        .load_val (ROB_CW'(ROB_SIZE)),
        .count    (rob_cr),
        .nonzero  (rob_nz)
    );

    dispatch_controller_credit_counter #(.SIZE(RS_SIZE)) u_rs_credit (
        .clk      (clk),
        .rst      (rst),
        .en       (rdy),
        .take     (fire && !head_lsb),
        .free     (rs_release_in),
        .load     (rollback_in),
        .load_val (RS_CW'(RS_SIZE)),
        .count    (rs_cr),
        .nonzero  (rs_nz)
    );

    dispatch_controller_credit_counter #(.SIZE(LSB_SIZE)) u_lsb_credit (
        .clk      (clk),
        .rst      (rst),
        .en       (rdy),
        .take     (fire && head_lsb),
        .free     (lsb_release_in),
        .load     (rollback_in),
        .load_val (lsb_free_after_rollback_in),
        .count    (lsb_cr),
        .nonzero  (lsb_nz)
    );

endmodule
